regfile_mp: RTL and testbench

//  Parametrised multi-port register file with operand bypass and a per-register busy scoreboard.

---
 rtl/regfile_mp.sv | 150 +++++++++++++++
 tb/tb_regfile_mp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-port CPU register bank with same-cycle write-to-read bypass and a
//   per-register busy scoreboard that tracks outstanding producers.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   ra           NRD read addresses, port j at ra[j*AW +: AW]
//   rd_data      NRD combinational read data words
//   rd_busy      NRD flags: read register still has an outstanding producer
//   we/wa/wd     NWR write ports; a higher port index has priority
//   iss_valid    issue strobe, marks iss_addr busy
//   iss_addr     destination register of the issuing instruction
//   wr_conflict  registered flag: the previous cycle had a write-address collision
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*DW-1:0]   rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*DW-1:0]   wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic                wr_conflict
);

    localparam int DEPTH   = 1 << AW;
    localparam bit ZERO_EN = (ZERO_REG != 32'sd0);

    logic [DW-1:0]    regf_q [DEPTH];
    logic [DW-1:0]    regf_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_conflict_q;
    logic             wr_conflict_d;

    // Next register contents: ports applied in ascending order so the highest index wins.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regf_d[r] = regf_q[r];
        end
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && !(ZERO_EN && (wa[i*AW +: AW] == {AW{1'b0}}))) begin
                regf_d[wa[i*AW +: AW]] = wd[i*DW +: DW];
            end else begin
                regf_d[0] = regf_d[0];
            end
        end
    end

    // Next busy vector: writes clear first, then an issue sets, so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (we[i]) begin
                busy_d[wa[i*AW +: AW]] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
        end
        if (iss_valid) begin
            busy_d[iss_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        // r0 is hardwired to zero and can never be waited on.
        if (ZERO_EN) begin
            busy_d[0] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
    end

    // Collision detect: any pair of enabled ports on the same (writable) address.
    always_comb begin
        wr_conflict_d = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int k = i + 1; k < NWR; k++) begin
                if (we[i] && we[k] && (wa[i*AW +: AW] == wa[k*AW +: AW]) &&
                    !(ZERO_EN && (wa[i*AW +: AW] == {AW{1'b0}}))) begin
                    wr_conflict_d = 1'b1;
                end else begin
                    wr_conflict_d = wr_conflict_d;
                end
            end
        end
    end

    // Read ports: zero register, then bypass from the highest matching write port, then storage.
    always_comb begin
        rd_data = {(NRD*DW){1'b0}};
        rd_busy = {NRD{1'b0}};
        for (int j = 0; j < NRD; j++) begin
            logic          hit;
            logic [DW-1:0] val;
            hit = 1'b0;
            val = regf_q[ra[j*AW +: AW]];
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (wa[i*AW +: AW] == ra[j*AW +: AW])) begin
                    hit = 1'b1;
                    val = wd[i*DW +: DW];
                end else begin
                    hit = hit;
                end
            end
            if (rst) begin
                // Outputs read as zero for as long as reset is held, even with writes pending.
                rd_data[j*DW +: DW] = {DW{1'b0}};
                rd_busy[j]          = 1'b0;
            end else if (ZERO_EN && (ra[j*AW +: AW] == {AW{1'b0}})) begin
                rd_data[j*DW +: DW] = {DW{1'b0}};
                rd_busy[j]          = 1'b0;
            end else begin
                rd_data[j*DW +: DW] = val;
                // A bypassed value is already valid, so the producer is no longer awaited.
                rd_busy[j]          = busy_q[ra[j*AW +: AW]] & ~hit;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regf_q[r] <= {DW{1'b0}};
            end
            busy_q        <= {DEPTH{1'b0}};
            wr_conflict_q <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regf_q[r] <= regf_d[r];
            end
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp with default parameters (DW=32, AW=5,
//   NRD=2, NWR=2, ZERO_REG=1). Inputs change 1 ns after a rising edge and
//   outputs are sampled 1 ns later, away from the active edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*DW-1:0]   wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                wr_conflict;

    int checks;
    int failures;

    regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .ra          (ra),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .iss_valid   (iss_valid),
        .iss_addr    (iss_addr),
        .wr_conflict (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we        = 2'b00;
        wa        = {NWR*AW{1'b0}};
        wd        = {NWR*DW{1'b0}};
        iss_valid = 1'b0;
        iss_addr  = 5'd0;
    endtask

    task automatic test_reset();
        // Colliding write to r5 (port 1 wins) plus an issue to r6.
        we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'hDEADBEEF, 32'h00000001};
        iss_valid = 1'b1; iss_addr = 5'd6;
        tick();
        idle_inputs();
        ra = {5'd6, 5'd5};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL reset_pre_data actual=%h expected=%h", rd_data[31:0], 32'hDEADBEEF);
        end
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            failures++; $display("FAIL reset_pre_busy actual=%b expected=1", rd_busy[1]);
        end
        checks++;
        if (wr_conflict !== 1'b1) begin
            failures++; $display("FAIL reset_pre_conflict actual=%b expected=1", wr_conflict);
        end
        // Mid-cycle assertion, away from any clock edge.
        rst = 1'b1;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h00000000) begin
            failures++; $display("FAIL reset_async_data actual=%h expected=%h", rd_data[31:0], 32'h0);
        end
        checks++;
        if (wr_conflict !== 1'b0) begin
            failures++; $display("FAIL reset_async_conflict actual=%b expected=0", wr_conflict);
        end
        tick();
        #2;
        rst = 1'b0;
        tick();
        checks++;
        if (rd_data[31:0] !== 32'h00000000) begin
            failures++; $display("FAIL reset_post_data actual=%h expected=%h", rd_data[31:0], 32'h0);
        end
        checks++;
        if (rd_busy !== 2'b00) begin
            failures++; $display("FAIL reset_post_busy actual=%b expected=00", rd_busy);
        end
        checks++;
        if (wr_conflict !== 1'b0) begin
            failures++; $display("FAIL reset_post_conflict actual=%b expected=0", wr_conflict);
        end
    endtask

    task automatic test_bypass();
        we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'h0, 32'h12345678};
        ra = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h12345678) begin
            failures++; $display("FAIL bypass_same_cycle actual=%h expected=%h", rd_data[31:0], 32'h12345678);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data[63:32] !== 32'h12345678) begin
            failures++; $display("FAIL bypass_stored actual=%h expected=%h", rd_data[63:32], 32'h12345678);
        end
    endtask

    task automatic test_conflict();
        we = 2'b11; wa = {5'd9, 5'd9}; wd = {32'h00000002, 32'h00000001};
        ra = {5'd1, 5'd9};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h00000002) begin
            failures++; $display("FAIL conflict_bypass_prio actual=%h expected=%h", rd_data[31:0], 32'h2);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (wr_conflict !== 1'b1) begin
            failures++; $display("FAIL conflict_flag actual=%b expected=1", wr_conflict);
        end
        checks++;
        if (rd_data[31:0] !== 32'h00000002) begin
            failures++; $display("FAIL conflict_stored_prio actual=%h expected=%h", rd_data[31:0], 32'h2);
        end
        tick();
        checks++;
        if (wr_conflict !== 1'b0) begin
            failures++; $display("FAIL conflict_clear actual=%b expected=0", wr_conflict);
        end
    endtask

    task automatic test_back_to_back();
        // Two distinct addresses in one cycle: no collision, both stored.
        we = 2'b11; wa = {5'd11, 5'd10}; wd = {32'hBBBB0011, 32'hAAAA0010};
        ra = {5'd11, 5'd10};
        tick();
        // Following cycle overwrites r10 only via port 1.
        we = 2'b10; wa = {5'd10, 5'd0}; wd = {32'hCAFE0010, 32'h0};
        #1;
        checks++;
        if (wr_conflict !== 1'b0) begin
            failures++; $display("FAIL b2b_no_conflict actual=%b expected=0", wr_conflict);
        end
        checks++;
        if (rd_data !== {32'hBBBB0011, 32'hCAFE0010}) begin
            failures++; $display("FAIL b2b_read actual=%h expected=%h", rd_data, {32'hBBBB0011, 32'hCAFE0010});
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hCAFE0010) begin
            failures++; $display("FAIL b2b_stored actual=%h expected=%h", rd_data[31:0], 32'hCAFE0010);
        end
    endtask

    task automatic test_zero_reg();
        we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'h0000FFFF, 32'h0000FFFF};
        iss_valid = 1'b1; iss_addr = 5'd0;
        ra = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            failures++; $display("FAIL zero_bypass actual=%h/%b expected=0/00", rd_data, rd_busy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            failures++; $display("FAIL zero_stored actual=%h/%b expected=0/0", rd_data[31:0], rd_busy[0]);
        end
        checks++;
        if (wr_conflict !== 1'b0) begin
            failures++; $display("FAIL zero_conflict actual=%b expected=0", wr_conflict);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        idle_inputs();
        ra = {5'd0, 5'd3};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            failures++; $display("FAIL sb_busy_set actual=%b expected=1", rd_busy[0]);
        end
        tick();
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            failures++; $display("FAIL sb_busy_hold actual=%b expected=1", rd_busy[0]);
        end
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h000000AA};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h000000AA) begin
            failures++; $display("FAIL sb_bypass actual=%b/%h expected=0/000000aa", rd_busy[0], rd_data[31:0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h000000AA) begin
            failures++; $display("FAIL sb_cleared actual=%b/%h expected=0/000000aa", rd_busy[0], rd_data[31:0]);
        end
    endtask

    task automatic test_set_wins();
        iss_valid = 1'b1; iss_addr = 5'd4;
        we = 2'b10; wa = {5'd4, 5'd0}; wd = {32'h55AA55AA, 32'h0};
        ra = {5'd0, 5'd4};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h55AA55AA) begin
            failures++; $display("FAIL setwin_pre actual=%b/%h expected=0/55aa55aa", rd_busy[0], rd_data[31:0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h55AA55AA) begin
            failures++; $display("FAIL setwin_post actual=%b/%h expected=1/55aa55aa", rd_busy[0], rd_data[31:0]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ra       = {NRD*AW{1'b0}};
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_bypass();
        test_conflict();
        test_back_to_back();
        test_zero_reg();
        test_scoreboard();
        test_set_wins();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
